// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divisor
// and a frame-length helper. The receiver imports this package as well.
package uart_pkg;

  localparam int TX_STATE_W           = 3;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

  typedef enum logic [TX_STATE_W-1:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int frame_cycles(input int clks_per_bit,
                                      input int data_bits,
                                      input int stop_bits,
                                      input int parity_bits);
    return (1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while running and emits a
// one-cycle tick on the final count of each bit period. Clear has priority
// and parks the count at zero so a new bit period starts aligned.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Clear,
  input  logic i_Run,
  output logic o_Tick
);

  localparam int             CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, wrap at the end of a bit period, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear)        cnt_d = '0;
    else if (i_Run)     cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge i_Clock) begin
    cnt_q <= cnt_d;
  end

  assign o_Tick = i_Run && !i_Clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: LSB-first serialiser with a one-entry holding register
// so a byte can be queued while a frame is on the line, giving gap-free
// back-to-back frames. Optional parity bit: define UART_TRANSMITTER_PARITY_EN.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
`ifdef UART_TRANSMITTER_PARITY_EN
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
`else
  parameter int STOP_BITS    = 1
`endif
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  input  logic [DATA_BITS-1:0] i_Data,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  output logic                 o_Tx,
  output logic                 o_Busy,
  output logic                 o_Done
);

  localparam int                 BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
`ifdef UART_TRANSMITTER_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic tick;
  logic load;
  logic done;
  logic xfer;

  assign o_Ready = !hold_full_q && i_Enable;
  assign xfer    = i_Valid && o_Ready;

  // Bit timing; held cleared while idle (or in reset) so a start bit always
  // gets a full bit period. Rolls over directly from stop into a new start.
  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_Clock (i_Clock),
    .i_Clear (!i_Reset || (state_q == TX_IDLE)),
    .i_Run   (state_q != TX_IDLE),
    .o_Tick  (tick)
  );

  // Frame sequencing, holding-register handshake and next line level.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;
    done        = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (hold_full_q) begin
          state_d = TX_START;
          load    = 1'b1;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TRANSMITTER_PARITY_EN
            state_d   = TX_PARITY;
`else
            state_d   = TX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TRANSMITTER_PARITY_EN
      TX_PARITY: begin
        if (tick) begin
          state_d   = TX_STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      TX_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            done      = 1'b1;
            bit_cnt_d = '0;
            // A queued byte starts its start bit with no idle cycle.
            if (hold_full_q) begin
              state_d = TX_START;
              load    = 1'b1;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Drain holding into the shifter; accept a new byte when empty.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (xfer) begin
      hold_d      = i_Data;
      hold_full_d = 1'b1;
    end

    // Line level follows the state being entered so o_Tx is a clean flop.
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TRANSMITTER_PARITY_EN
      TX_PARITY: tx_d = par_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

`ifdef UART_TRANSMITTER_PARITY_EN
  // Parity of the frame's payload, fixed when the byte enters the shifter.
  always_comb begin
    par_d = par_q;
    if (load) par_d = (^hold_q) ^ PARITY_ODD;
  end
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state_q     <= TX_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
`ifdef UART_TRANSMITTER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
`ifdef UART_TRANSMITTER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign o_Tx   = tx_q;
  assign o_Busy = (state_q != TX_IDLE) || hold_full_q;
  assign o_Done = done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at CLKS_PER_BIT=4. Accepted bytes
// go into a scoreboard queue; a line monitor decodes each frame bit-exactly
// and pops/compares. Parity cases run when UART_TRANSMITTER_PARITY_EN is set.
module tb_uart_transmitter;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TRANSMITTER_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FRAME = (1 + DB + PB + SB) * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DB-1:0] din;
  logic          vld;
  logic          rdy, tx, busy, done;

  int n_tot = 0;
  int n_bad = 0;

  logic [DB-1:0] sb[$];

  int cyc_cnt = 0;
  int acc_cyc = 0;
  int last_done = 0;
  int last_end = 0;
  int last_gap = -1;
  int nframes = 0;
  bit have_end = 0;
  bit in_frame = 0;
  int fcyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB)
  ) dut (
    .i_Clock  (clk),
    .i_Reset  (rst_n),
    .i_Enable (en),
    .i_Data   (din),
    .i_Valid  (vld),
    .o_Ready  (rdy),
    .o_Tx     (tx),
    .o_Busy   (busy),
    .o_Done   (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Line monitor: samples mid-cycle, checks every cycle of a frame.
  logic [DB-1:0] rx;
  always @(negedge clk) begin
    int pos;
    logic exp_bit;
    if (!rst_n) begin
      in_frame = 0;
      have_end = 0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1;
        fcyc     = 0;
        rx       = '0;
        if (have_end) last_gap = cyc_cnt - last_end - 1;
      end
      if (in_frame) begin
        pos = fcyc / CPB;
        if (pos == 0) exp_bit = 1'b0;
        else if (pos <= DB) begin
          if (fcyc % CPB == 0) rx[pos-1] = tx;
          exp_bit = rx[pos-1];
        end
        else if (PB != 0 && pos == DB + 1) exp_bit = ^rx;
        else exp_bit = 1'b1;
        chk("tx_bit", 32'(tx), 32'(exp_bit));
        chk("done_pulse", 32'(done), 32'(fcyc == FRAME - 1));
        if (fcyc == FRAME - 1) begin
          chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) chk("data", 32'(rx), 32'(sb.pop_front()));
          in_frame  = 0;
          last_end  = cyc_cnt;
          last_done = cyc_cnt;
          have_end  = 1;
          nframes++;
        end else begin
          fcyc++;
        end
      end else begin
        chk("done_idle", 32'(done), 32'd0);
      end
    end
  end

  // Offer a byte and wait (bounded) for the handshake; push on acceptance.
  task automatic send(input logic [DB-1:0] b);
    bit ok = 0;
    vld = 1'b1;
    din = b;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (rdy) begin
        sb.push_back(b);
        ok = 1;
      end
      @(posedge clk); #1;
      if (ok) acc_cyc = cyc_cnt;
    end
    vld = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 0;
    for (int n = 0; n < max_cyc && !ok; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !in_frame && !busy) ok = 1;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, a0;
    bit seen_low;
    bit ok;
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(rdy), 32'd1);

    // Single frame, latency and ready profile.
    send(8'hA5);
    chk("a5_hold_ready", 32'(rdy), 32'd0);
    chk("a5_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("a5_drain_ready", 32'(rdy), 32'd1);
    repeat (10) @(posedge clk);
    #1 chk("a5_mid_ready", 32'(rdy), 32'd1);
    wait_idle(200);
    chk("a5_latency", 32'(last_done - acc_cyc), 32'(FRAME));

    // Back-to-back frames with no idle gap.
    repeat (5) @(posedge clk);
    #1 f0 = nframes;
    send(8'h00);
    a0 = acc_cyc;
    send(8'hFF);
    wait_idle(300);
    chk("b2b_frames", 32'(nframes - f0), 32'd2);
    chk("b2b_gap", 32'(last_gap), 32'd0);
    chk("b2b_total", 32'(last_done - a0), 32'(2 * FRAME));

    // Enable low blocks acceptance; dropping it mid-frame is harmless.
    en = 1'b0; vld = 1'b1; din = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("en_ready", 32'(rdy), 32'd0);
      chk("en_tx", 32'(tx), 32'd1);
      chk("en_busy", 32'(busy), 32'd0);
    end
    vld = 1'b0; en = 1'b1;
    #1 f0 = nframes;
    send(8'h3C);
    repeat (12) @(posedge clk);
    #1 en = 1'b0;
    #1 chk("en_mid_ready", 32'(rdy), 32'd0);
    wait_idle(200);
    chk("en_mid_frames", 32'(nframes - f0), 32'd1);
    en = 1'b1;

    // Reset during bit 3 with a second byte held.
    send(8'h55);
    send(8'hAA);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      if (in_frame && (fcyc / CPB) == 4) ok = 1;
    end
    chk("rst_reach_bit3", 32'(ok), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    f0 = nframes;
    seen_low = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) seen_low = 1;
    end
    chk("no_stray_low", 32'(seen_low), 32'd0);
    chk("no_stray_frame", 32'(nframes - f0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Holding full: ready low, new data ignored.
    f0 = nframes;
    send(8'h11);
    send(8'h22);
    vld = 1'b1; din = 8'h33;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("full_ready", 32'(rdy), 32'd0);
      if (i == 1) din = 8'h44;
    end
    vld = 1'b0;
    wait_idle(300);
    chk("full_frames", 32'(nframes - f0), 32'd2);

`ifdef UART_TRANSMITTER_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0 (checked by the monitor).
    send(8'h07);
    wait_idle(200);
    chk("par_latency", 32'(last_done - acc_cyc), 32'd44);
    send(8'h03);
    wait_idle(200);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
